mem_output_packer: RTL and testbench

MEM_OUTPUT_PACKER -- requirements
Module: mem_output_packer

---
 rtl/smem_pkg.sv | 48 ++++
 rtl/mem_entry_unpack.sv | 18 +
 rtl/mem_output_packer.sv | 204 ++++++++++++++++++++
 tb/tb_mem_output_packer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smem_pkg.sv
// Shared constants for the mem-queue output packer: geometry, entry/beat field
// offsets and the packer FSM state encoding.
package smem_pkg;

  localparam int SMEM_READ_LEN       = 101;
  localparam int SMEM_READ_NUM_WIDTH = 8;
  localparam int SMEM_ADDR_WIDTH     = 15;

  localparam int CNT_W   = 7;
  localparam int ENTRY_W = 113;
  localparam int HALF_W  = 256;
  localparam int BEAT_W  = 512;

  // Entry field -> half-beat lane mapping (source lsb, destination lsb, width)
  localparam int FLD0_SRC = 0;
  localparam int FLD0_DST = 0;
  localparam int FLD0_W   = 33;
  localparam int FLD1_SRC = 33;
  localparam int FLD1_DST = 64;
  localparam int FLD1_W   = 33;
  localparam int FLD2_SRC = 66;
  localparam int FLD2_DST = 128;
  localparam int FLD2_W   = 33;
  localparam int FLD3_SRC = 99;
  localparam int FLD3_DST = 192;
  localparam int FLD3_W   = 7;
  localparam int FLD4_SRC = 106;
  localparam int FLD4_DST = 224;
  localparam int FLD4_W   = 7;

  // Header beat layout
  localparam int HDR_PTR_LSB  = 0;
  localparam int HDR_PTR_W    = 10;
  localparam int HDR_SIZE_LSB = 64;
  localparam int HDR_RET_LSB  = 128;
  localparam int HDR_RET_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_HDR   = 3'd2,
    ST_FETCH = 3'd3,
    ST_EMIT  = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } smem_state_e;

endpackage

// File: rtl/mem_entry_unpack.sv
// Spreads one 113-bit mem-queue entry across a 256-bit half-beat; unused lanes are zero.
module mem_entry_unpack
  import smem_pkg::*;
(
  input  logic [ENTRY_W-1:0] i_entry,
  output logic [HALF_W-1:0]  o_half
);

  always_comb begin
    o_half = '0;
    o_half[FLD0_DST +: FLD0_W] = i_entry[FLD0_SRC +: FLD0_W];
    o_half[FLD1_DST +: FLD1_W] = i_entry[FLD1_SRC +: FLD1_W];
    o_half[FLD2_DST +: FLD2_W] = i_entry[FLD2_SRC +: FLD2_W];
    o_half[FLD3_DST +: FLD3_W] = i_entry[FLD3_SRC +: FLD3_W];
    o_half[FLD4_DST +: FLD4_W] = i_entry[FLD4_SRC +: FLD4_W];
  end

endmodule

// File: rtl/mem_output_packer.sv
// Walks a batch of reads, emitting one header beat per read followed by its
// mem-queue entries packed two per 512-bit beat, under stall/permit flow control.
module mem_output_packer
  import smem_pkg::*;
#(
  parameter int READ_LEN       = SMEM_READ_LEN,
  parameter int READ_NUM_WIDTH = SMEM_READ_NUM_WIDTH,
  parameter int ADDR_WIDTH     = SMEM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [READ_NUM_WIDTH:0]   batch_size,
  input  logic                      start,
  output logic                      output_request,
  input  logic                      output_permit,
  input  logic                      stall,
  output logic [READ_NUM_WIDTH-1:0] info_rd_num,
  input  logic [CNT_W-1:0]          mem_size_in,
  input  logic [CNT_W-1:0]          ret_in,
  output logic                      mem_rd_en,
  output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
  input  logic [ENTRY_W-1:0]        mem_rd_q,
  output logic [BEAT_W-1:0]         output_data,
  output logic                      output_valid,
  output logic                      output_finish
);

  smem_state_e               r_state;
  smem_state_e               w_state_nxt;
  logic [READ_NUM_WIDTH:0]   r_batch;
  logic [READ_NUM_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0]     r_base;
  logic [CNT_W-1:0]          r_idx;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_sub;
  logic                      r_cap_v;
  logic                      r_cap_slot;
  logic [ENTRY_W-1:0]        r_slot0;
  logic [ENTRY_W-1:0]        r_slot1;
  logic                      r_req;
  logic                      r_valid;
  logic                      r_finish;
  logic [BEAT_W-1:0]         r_data;

  logic                      w_go;
  logic                      w_load;
  logic                      w_hdr_go;
  logic                      w_issue;
  logic                      w_emit;
  logic                      w_next_go;
  logic                      w_pair;
  logic [CNT_W:0]            w_idx_inc;
  logic [READ_NUM_WIDTH:0]   w_ptr_inc;
  logic [BEAT_W-1:0]         w_hdr;
  logic [HALF_W-1:0]         w_half0;
  logic [HALF_W-1:0]         w_half1;

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] size);
    return (int'(size) > READ_LEN) ? CNT_W'(READ_LEN) : size;
  endfunction

  assign w_go      = ~stall & output_permit;
  assign w_idx_inc = {1'b0, r_idx} + 1'b1;
  assign w_ptr_inc = {1'b0, r_ptr} + 1'b1;
  // A second read joins the pair only if the entry after idx exists
  assign w_pair    = ~r_sub & (w_idx_inc < {1'b0, r_cnt});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_hdr_go    = 1'b0;
    w_issue     = 1'b0;
    w_emit      = 1'b0;
    w_next_go   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (output_permit) w_state_nxt = (r_batch != '0) ? ST_HDR : ST_DONE;
      end
      ST_HDR: begin
        if (w_go) begin
          w_hdr_go    = 1'b1;
          w_state_nxt = (mem_size_in == '0) ? ST_NEXT : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (w_go) begin
          w_issue     = 1'b1;
          w_state_nxt = w_pair ? ST_FETCH : ST_EMIT;
        end
      end
      ST_EMIT: begin
        // Wait for the last read of the pair to land before emitting
        if (w_go && !r_cap_v) begin
          w_emit      = 1'b1;
          w_state_nxt = (r_idx < r_cnt) ? ST_FETCH : ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (w_go) begin
          w_next_go   = 1'b1;
          w_state_nxt = (w_ptr_inc < r_batch) ? ST_HDR : ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_hdr = '0;
    w_hdr[HDR_PTR_LSB +: HDR_PTR_W]  = HDR_PTR_W'(r_ptr);
    w_hdr[HDR_SIZE_LSB +: CNT_W]     = mem_size_in;
    w_hdr[HDR_RET_LSB +: HDR_RET_W]  = HDR_RET_W'(ret_in);
  end

  mem_entry_unpack u_unpack0 (
    .i_entry (r_slot0),
    .o_half  (w_half0)
  );

  mem_entry_unpack u_unpack1 (
    .i_entry (r_slot1),
    .o_half  (w_half1)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_batch    <= '0;
      r_ptr      <= '0;
      r_base     <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_sub      <= 1'b0;
      r_cap_v    <= 1'b0;
      r_cap_slot <= 1'b0;
      r_slot0    <= '0;
      r_slot1    <= '0;
    end else begin
      if (w_load) begin
        r_batch <= batch_size;
        r_ptr   <= '0;
        r_base  <= '0;
        r_idx   <= '0;
        r_sub   <= 1'b0;
      end
      if (w_hdr_go) begin
        r_cnt <= clamp_cnt(mem_size_in);
        r_idx <= '0;
        r_sub <= 1'b0;
      end
      if (w_issue) begin
        r_idx      <= w_idx_inc[CNT_W-1:0];
        r_sub      <= w_pair;
        r_cap_slot <= r_sub;
        if (!r_sub) r_slot1 <= '0;
      end
      r_cap_v <= w_issue;
      // Capture is independent of stall so an in-flight read is never lost
      if (r_cap_v) begin
        if (r_cap_slot) r_slot1 <= mem_rd_q;
        else            r_slot0 <= mem_rd_q;
      end
      if (w_next_go) begin
        r_ptr  <= w_ptr_inc[READ_NUM_WIDTH-1:0];
        r_base <= r_base + ADDR_WIDTH'(READ_LEN);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_finish <= 1'b0;
      r_data   <= '0;
    end else begin
      r_req    <= (w_state_nxt == ST_REQ);
      r_valid  <= w_hdr_go | w_emit;
      r_finish <= r_finish | (w_state_nxt == ST_DONE);
      if (w_hdr_go)    r_data <= w_hdr;
      else if (w_emit) r_data <= {w_half1, w_half0};
    end
  end

  assign output_request = r_req;
  assign output_valid   = r_valid;
  assign output_finish  = r_finish;
  assign output_data    = r_data;
  assign info_rd_num    = r_ptr;
  assign mem_rd_en      = w_issue;
  assign mem_rd_addr    = w_issue ? (r_base + {{(ADDR_WIDTH-CNT_W){1'b0}}, r_idx}) : '0;

endmodule

// File: tb/tb_mem_output_packer.sv
// Scoreboard bench for mem_output_packer: a reference model queues expected
// beats and read addresses per batch; a monitor pops and compares them.
module tb_mem_output_packer;

  localparam int RL  = 101;
  localparam int RNW = 8;
  localparam int AW  = 15;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [RNW:0]   batch_size;
  logic           start;
  logic           output_request;
  logic           output_permit;
  logic           stall;
  logic [RNW-1:0] info_rd_num;
  logic [6:0]     mem_size_in;
  logic [6:0]     ret_in;
  logic           mem_rd_en;
  logic [AW-1:0]  mem_rd_addr;
  logic [112:0]   mem_rd_q;
  logic [511:0]   output_data;
  logic           output_valid;
  logic           output_finish;

  logic [6:0]   sizes [256];
  logic [6:0]   rets  [256];
  logic [112:0] mem   [32768];

  logic [511:0] exp_q[$];
  int           addr_q[$];
  int           checks = 0;
  int           errors = 0;
  int           beats = 0;
  int           exp_beats = 0;
  int           last_addr = -1;
  bit           rand_en = 1'b0;
  int           stall_pct = 0;
  int           permit_pct = 100;
  logic         frz_q = 1'b0;

  always #5 clk = ~clk;

  mem_output_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .batch_size     (batch_size),
    .start          (start),
    .output_request (output_request),
    .output_permit  (output_permit),
    .stall          (stall),
    .info_rd_num    (info_rd_num),
    .mem_size_in    (mem_size_in),
    .ret_in         (ret_in),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_q       (mem_rd_q),
    .output_data    (output_data),
    .output_valid   (output_valid),
    .output_finish  (output_finish)
  );

  assign mem_size_in = sizes[info_rd_num];
  assign ret_in      = rets[info_rd_num];

  // Synchronous memory: data valid the cycle after the strobe, junk otherwise
  always @(posedge clk) begin : memq
    logic [127:0] j;
    j = {$urandom, $urandom, $urandom, $urandom};
    if (mem_rd_en) mem_rd_q <= mem[mem_rd_addr];
    else           mem_rd_q <= j[112:0];
  end

  always @(posedge clk) frz_q <= stall | ~output_permit;

  function automatic logic [255:0] unpack(input logic [112:0] q);
    logic [255:0] h;
    h = '0;
    h[32:0]    = q[32:0];
    h[96:64]   = q[65:33];
    h[160:128] = q[98:66];
    h[198:192] = q[105:99];
    h[230:224] = q[112:106];
    return h;
  endfunction

  always @(negedge clk) begin : monitor
    logic [511:0] e;
    int a;
    if (reset_n) begin
      if (output_valid) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got %h, expected no beat", output_data);
        end else begin
          e = exp_q.pop_front();
          if (output_data !== e) begin
            errors++;
            $display("FAIL beat_data: got %h expected %h", output_data, e);
          end
        end
      end
      if (mem_rd_en) begin
        last_addr = int'(mem_rd_addr);
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got addr %0d, expected no read", mem_rd_addr);
        end else begin
          a = addr_q.pop_front();
          if (int'(mem_rd_addr) != a) begin
            errors++;
            $display("FAIL rd_addr: got %0d expected %0d", mem_rd_addr, a);
          end
        end
      end
      if (stall || !output_permit) begin
        checks++;
        if (mem_rd_en) begin
          errors++;
          $display("FAIL rd_while_frozen: got mem_rd_en=1 expected 0");
        end
      end
      if (frz_q) begin
        checks++;
        if (output_valid) begin
          errors++;
          $display("FAIL valid_after_freeze: got output_valid=1 expected 0");
        end
      end
    end
  end

  task automatic check_val(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_en) begin
      stall         = ($urandom_range(99) < stall_pct);
      output_permit = ($urandom_range(99) < permit_pct);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic model_batch(input int nb);
    logic [511:0] b;
    logic [255:0] h0, h1;
    int n, base;
    exp_beats = 0;
    for (int p = 0; p < nb; p++) begin
      b = '0;
      b[9:0]     = 10'(p);
      b[70:64]   = sizes[p];
      b[159:128] = {25'd0, rets[p]};
      exp_q.push_back(b);
      exp_beats++;
      n    = (int'(sizes[p]) > RL) ? RL : int'(sizes[p]);
      base = p * RL;
      for (int k = 0; k < n; k += 2) begin
        addr_q.push_back(base + k);
        h0 = unpack(mem[base + k]);
        h1 = '0;
        if (k + 1 < n) begin
          addr_q.push_back(base + k + 1);
          h1 = unpack(mem[base + k + 1]);
        end
        exp_q.push_back({h1, h0});
        exp_beats++;
      end
    end
  endtask

  task automatic kick(input int nb);
    beats      = 0;
    model_batch(nb);
    batch_size = (RNW+1)'(nb);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_finish(input string name, input int maxc);
    int c;
    c = 0;
    while (!output_finish && c < maxc) begin
      tick();
      c++;
    end
    check_val({name, "_finish"}, 512'(output_finish), 512'(1));
    repeat (4) tick();
    check_val({name, "_beats"}, 512'(beats), 512'(exp_beats));
    check_val({name, "_queues_left"}, 512'(exp_q.size() + addr_q.size()), 512'(0));
    check_val({name, "_valid_in_done"}, 512'(output_valid), 512'(0));
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic rand_sizes(input int nb, input int maxsz);
    for (int p = 0; p < nb; p++) begin
      sizes[p] = 7'($urandom_range(maxsz));
      rets[p]  = 7'($urandom_range(127));
    end
  endtask

  initial begin
    logic [127:0] w;
    reset_n       = 1'b0;
    start         = 1'b0;
    stall         = 1'b0;
    output_permit = 1'b0;
    batch_size    = '0;
    for (int i = 0; i < 32768; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      mem[i] = w[112:0];
    end
    for (int p = 0; p < 256; p++) begin
      sizes[p] = '0;
      rets[p]  = '0;
    end

    repeat (2) tick();
    check_val("reset_ctrl", 512'({output_request, output_valid, output_finish, mem_rd_en}), 512'(0));
    check_val("reset_data", output_data, 512'(0));
    check_val("reset_rdnum_addr", 512'({info_rd_num, mem_rd_addr}), 512'(0));
    reset_n       = 1'b1;
    output_permit = 1'b1;
    tick();

    // Single read with no entries
    sizes[0] = 7'd0;
    rets[0]  = 7'd5;
    kick(1);
    check_val("req_raised", 512'(output_request), 512'(1));
    wait_finish("size0", 200);
    do_reset();

    // Empty batch
    kick(0);
    wait_finish("batch0", 200);
    do_reset();

    // Two reads, odd then even entry count
    sizes[0] = 7'd3;
    sizes[1] = 7'd2;
    rets[0]  = 7'd17;
    rets[1]  = 7'd99;
    kick(2);
    wait_finish("sizes_3_2", 400);
    do_reset();

    // Stall held three cycles after the first data beat
    sizes[0] = 7'd4;
    rets[0]  = 7'd1;
    kick(1);
    for (int c = 0; c < 200 && beats < 2; c++) tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    wait_finish("stall3", 200);
    do_reset();

    // Random batches with random stall and permit drops, including clamped sizes
    for (int t = 0; t < 4; t++) begin
      int nb;
      nb = $urandom_range(12, 1);
      rand_sizes(nb, 127);
      rand_en    = 1'b1;
      stall_pct  = 25;
      permit_pct = 80;
      kick(nb);
      wait_finish("random", 20000);
      rand_en       = 1'b0;
      stall         = 1'b0;
      output_permit = 1'b1;
      do_reset();
    end

    // Full-width batch reaching the top address
    rand_sizes(256, 6);
    sizes[10]  = 7'd127;
    sizes[255] = 7'd101;
    rand_en    = 1'b1;
    stall_pct  = 10;
    permit_pct = 95;
    kick(256);
    wait_finish("batch256", 40000);
    check_val("last_addr", 512'(last_addr), 512'(25855));
    rand_en       = 1'b0;
    stall         = 1'b0;
    output_permit = 1'b1;
    do_reset();

    // Asynchronous reset in the middle of read 1, then a clean rerun
    rand_sizes(3, 6);
    sizes[1] = 7'd8;
    kick(3);
    for (int c = 0; c < 500 && info_rd_num != 8'd1; c++) tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_val("abort_ctrl", 512'({output_request, output_valid, output_finish, mem_rd_en}), 512'(0));
    check_val("abort_data", output_data, 512'(0));
    check_val("abort_rdnum", 512'(info_rd_num), 512'(0));
    exp_q.delete();
    addr_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    kick(3);
    wait_finish("rerun", 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
